// File: rtl/mini_mips_pkg.sv
// Shared constants for the Mini MIPS fetch/decode boundary: field widths, opcodes
// and the fetch FSM state encodings.
package mini_mips_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 16;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LW   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SW   = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_J    = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;
    localparam logic [STATE_W-1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: synchronous reset to RESET_PC, a redirect load that wins over
// increment, and a modulo-2^PC_W increment.
module pc_register #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: PC ownership, instruction-memory request FSM and the decode-side
// output buffer. Optional halt detection is enabled by defining IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = mini_mips_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic                               imem_req,
    output logic [PC_W-1:0]                    imem_addr,
    input  logic                               imem_ack,
    input  logic [INSTR_W-1:0]                 imem_rdata,
    output logic                               if_valid,
    input  logic                               id_ready,
    output logic [INSTR_W-1:0]                 if_instr,
    output logic [mini_mips_pkg::OPCODE_W-1:0] if_opcode,
    output logic [PC_W-1:0]                    if_pc,
    input  logic                               redirect_en,
    input  logic [PC_W-1:0]                    redirect_pc,
    output logic                               halted
);

    import mini_mips_pkg::*;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [PC_W-1:0]    pc;
    logic               redirect_take;
    logic               halt_seen;
    logic               capture;
    logic               consume;

`ifdef IFU_HALT_DETECT_EN
    // Once halted, only reset restarts fetch, so redirects are masked here.
    assign redirect_take = redirect_en && (state != ST_HALT);
    assign halt_seen     = (if_opcode == OP_HALT);
    assign halted        = (state == ST_HALT);
`else
    assign redirect_take = redirect_en;
    assign halt_seen     = 1'b0;
    assign halted        = 1'b0;
`endif

    // A redirect in the ack cycle discards the returned word; a redirect in HOLD flushes it.
    assign capture   = (state == ST_REQ)  && imem_ack && !redirect_take;
    assign consume   = (state == ST_HOLD) && if_valid && id_ready && !redirect_take;
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    pc_register #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .load       (redirect_take),
        .load_value (redirect_pc),
        .inc        (capture),
        .pc         (pc)
    );

    always_comb begin
        // NOTE: default assignment first, so no path through this block infers a latch.
        next_state = state;
        case (state)
            ST_IDLE: next_state = ST_REQ;
            ST_REQ:  if (capture) next_state = ST_HOLD;
            ST_HOLD: if (consume) next_state = halt_seen ? ST_HALT : ST_REQ;
`ifdef IFU_HALT_DETECT_EN
            ST_HALT: next_state = ST_HALT;
`endif
            default: next_state = ST_IDLE;
        endcase
        if (redirect_take) begin
            next_state = ST_REQ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Output buffer only moves on capture, consume, flush or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_opcode <= '0;
            if_pc     <= '0;
        end else if (redirect_take) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_valid  <= 1'b1;
            if_instr  <= imem_rdata;
            if_opcode <= imem_rdata[INSTR_W-1 -: OPCODE_W];
            if_pc     <= pc;
        end else if (consume) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a word-addressed memory model answers
// requests and a scoreboard queue tracks captured words until decode consumes them.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [15:0] if_instr;
    logic [3:0]  if_opcode;
    logic [7:0]  if_pc;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic        halted;

    logic [15:0] mem [256];
    exp_t        q[$];
    logic [7:0]  exp_pc;
    logic        exp_idle;
    logic        exp_halted;
    int          n_checks;
    int          n_fail;

    instr_fetch_unit #(
        .PC_W     (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: checks DUT outputs against the model, drives inputs
    // for the next rising edge, updates the model and advances one cycle.
    task automatic cycle(input logic ack, input logic rdy,
                         input logic redir = 1'b0, input logic [7:0] rpc = 8'h00);
        logic exp_valid;
        logic exp_req;
        exp_t e;
        exp_valid = (q.size() != 0);
        exp_req   = !exp_halted && !exp_idle && !exp_valid;

        imem_ack    = ack;
        id_ready    = rdy;
        redirect_en = redir;
        redirect_pc = rpc;
        imem_rdata  = imem_req ? mem[imem_addr] : 16'hBAD0;

        check("if_valid", 32'(if_valid), 32'(exp_valid));
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("halted", 32'(halted), 32'(exp_halted));
        if (exp_req) check("imem_addr", 32'(imem_addr), 32'(exp_pc));
        if (exp_valid) begin
            check("if_instr", 32'(if_instr), 32'(q[0].instr));
            check("if_opcode", 32'(if_opcode), 32'(q[0].instr[15:12]));
            check("if_pc", 32'(if_pc), 32'(q[0].pc));
        end

        if (redir && !exp_halted) begin
            q.delete();
            exp_pc = rpc;
        end else begin
            if (exp_valid && rdy) begin
                e = q.pop_front();
`ifdef IFU_HALT_DETECT_EN
                if (e.instr[15:12] == 4'hF) exp_halted = 1'b1;
`endif
            end
            if (exp_req && ack) begin
                q.push_back('{instr: mem[exp_pc], pc: exp_pc});
                exp_pc = exp_pc + 8'd1;
            end
        end
        exp_idle = 1'b0;

        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_ack    = 1'b0;
        id_ready    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 8'h00;
        imem_rdata  = 16'h0000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst imem_addr", 32'(imem_addr), 32'h00);
        check("rst if_valid", 32'(if_valid), 32'd0);
        check("rst if_instr", 32'(if_instr), 32'h0000);
        check("rst if_opcode", 32'(if_opcode), 32'h0);
        check("rst if_pc", 32'(if_pc), 32'h00);
        check("rst halted", 32'(halted), 32'd0);
        reset = 1'b0;
        q.delete();
        exp_pc     = 8'h00;
        exp_idle   = 1'b1;
        exp_halted = 1'b0;
    endtask

    // Drain any held word and step until the model expects a request (bounded).
    task automatic wait_req();
        int n;
        n = 0;
        while ((exp_idle || q.size() != 0) && !exp_halted && n < 8) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        check("wait_req timeout", 32'(n < 8), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 256; a++) begin
            mem[a] = {1'b0, 3'(a), 4'h5, 8'(a)};
        end
        mem[8'h00] = 16'h1234;
        mem[8'h40] = 16'hF00D;

        // Reset and back-to-back fetch: addresses 0,1,2,... every two cycles.
        do_reset();
        repeat (10) cycle(1'b1, 1'b1);

        // Decode stalls for five cycles; acks seen outside REQ must be ignored.
        wait_req();
        cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);

        // Memory answers three cycles late; address must stay put.
        wait_req();
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);

        // Redirect in the ack cycle: data discarded, next request at 8'h20.
        wait_req();
        cycle(1'b1, 1'b1, 1'b1, 8'h20);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);

        // Redirect while a word is held and decode is ready: flush wins.
        wait_req();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h30);
        repeat (4) cycle(1'b1, 1'b1);

        // PC wraps from 8'hFF to 8'h00 without a flag.
        wait_req();
        cycle(1'b0, 1'b0, 1'b1, 8'hFE);
        repeat (6) cycle(1'b1, 1'b1);

        // Opcode 4'hF: halts fetch when halt detection is built in, otherwise fetched normally.
        wait_req();
        cycle(1'b0, 1'b0, 1'b1, 8'h40);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'h10);
        repeat (4) cycle(1'b1, 1'b1);

        // Reset in the middle of an outstanding request drops it.
        do_reset();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        do_reset();
        repeat (4) cycle(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
